// File: rtl/musk_arb_pkg.sv
// Shared types and helpers for the Sysbus request/response arbiter.
package musk_arb_pkg;

  // Tag width the table entry is built for; the arbiter's TAG_W must match.
  localparam int ARB_TAG_W = 13;
  // Owner index width, wide enough for up to 8 requesters.
  localparam int ARB_OWN_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [ARB_TAG_W-1:0] tag;
    logic [ARB_OWN_W-1:0] owner;
  } tbl_entry_t;

  // The top tag bit marks a write; writes never get a response.
  function automatic logic is_write(input logic [ARB_TAG_W-1:0] tag);
    return tag[ARB_TAG_W-1];
  endfunction

endpackage

// File: rtl/musk_tag_table.sv
// Outstanding-read table: remembers which requester owns each in-flight read tag.
module musk_tag_table
  import musk_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int MAX_OUT = 4,
  localparam int IDX_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1,
  localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alloc_en,
  input  logic [ARB_TAG_W-1:0]      alloc_tag,
  input  logic [ARB_OWN_W-1:0]      alloc_owner,
  input  logic [ARB_TAG_W-1:0]      lookup_tag,
  output logic                      lookup_hit,
  output logic [ARB_OWN_W-1:0]      lookup_owner,
  output logic [IDX_W-1:0]          lookup_idx,
  input  logic                      free_en,
  input  logic [IDX_W-1:0]          free_idx,
  input  logic [NREQ*ARB_TAG_W-1:0] query_tags,
  output logic [NREQ-1:0]           query_hit,
  output logic [CNT_W-1:0]          count
);

  tbl_entry_t       tbl_q [MAX_OUT];
  tbl_entry_t       new_ent;
  logic [IDX_W-1:0] alloc_idx;

  assign new_ent = '{valid: 1'b1, tag: alloc_tag, owner: alloc_owner};

  // Response lookup; tags are unique in the table so the lowest hit is the only hit.
  always_comb begin
    lookup_hit   = 1'b0;
    lookup_owner = '0;
    lookup_idx   = '0;
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      if (tbl_q[i].valid && (tbl_q[i].tag == lookup_tag)) begin
        lookup_hit   = 1'b1;
        lookup_owner = tbl_q[i].owner;
        lookup_idx   = IDX_W'(i);
      end
    end
  end

  // Lowest free slot takes the next allocation; caller guarantees one exists.
  always_comb begin
    alloc_idx = '0;
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      if (!tbl_q[i].valid) alloc_idx = IDX_W'(i);
    end
  end

  // Per-requester "tag already outstanding" query used for eligibility.
  always_comb begin
    query_hit = '0;
    for (int r = 0; r < NREQ; r++) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (tbl_q[i].valid && (tbl_q[i].tag == query_tags[r*ARB_TAG_W +: ARB_TAG_W]))
          query_hit[r] = 1'b1;
      end
    end
  end

  // Entry storage and occupancy; alloc and free may land in the same cycle on different slots.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MAX_OUT; i++) tbl_q[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (free_en && (free_idx == IDX_W'(i))) tbl_q[i].valid <= 1'b0;
        if (alloc_en && (alloc_idx == IDX_W'(i))) tbl_q[i] <= new_ent;
      end
      count <= count + CNT_W'(alloc_en) - CNT_W'(free_en);
    end
  end

endmodule

// File: rtl/musk_bus_arbiter.sv
// Round-robin arbiter sharing one Sysbus request/response channel among NREQ requesters.
//
//   state | meaning
//   IDLE  | no transaction owns the bus; pick the next eligible requester
//   ADDR  | granted requester's address beat passed through to the bus
//   DATA  | write data beats passed through until WR_BEATS are accepted
module musk_bus_arbiter
  import musk_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int DATA_W     = 64,
  parameter int TAG_W      = ARB_TAG_W,
  parameter int WR_BEATS   = 8,
  parameter int RESP_BEATS = 8,
  parameter int MAX_OUT    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        m_reqcyc,
  input  logic [NREQ*DATA_W-1:0] m_req,
  input  logic [NREQ*TAG_W-1:0]  m_reqtag,
  output logic [NREQ-1:0]        m_reqack,
  output logic [NREQ-1:0]        m_respcyc,
  output logic [DATA_W-1:0]      m_resp,
  output logic [TAG_W-1:0]       m_resptag,
  input  logic [NREQ-1:0]        m_respack,
  output logic                   bus_reqcyc,
  output logic [DATA_W-1:0]      bus_req,
  output logic [TAG_W-1:0]       bus_reqtag,
  input  logic                   bus_reqack,
  input  logic                   bus_respcyc,
  input  logic [DATA_W-1:0]      bus_resp,
  input  logic [TAG_W-1:0]       bus_resptag,
  output logic                   bus_respack,
  output logic                   err_orphan
);

  localparam int IDX_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W  = $clog2(MAX_OUT + 1);
  localparam int BEAT_W = (WR_BEATS > 1) ? $clog2(WR_BEATS) : 1;
  localparam int RCNT_W = (RESP_BEATS > 1) ? $clog2(RESP_BEATS) : 1;

  state_e               state_q, state_d;
  logic [ARB_OWN_W-1:0] grant_q, grant_d;
  logic [ARB_OWN_W-1:0] rr_q, rr_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [RCNT_W-1:0]    resp_cnt_q, resp_cnt_d;
  logic                 err_q;

  logic                 sel_cyc;
  logic [DATA_W-1:0]    sel_req;
  logic [TAG_W-1:0]     sel_tag;
  logic [NREQ-1:0]      grant_ack;
  logic [NREQ-1:0]      elig;
  logic                 found;
  logic [ARB_OWN_W-1:0] winner;
  logic                 alloc_en;

  logic                 lookup_hit;
  logic [ARB_OWN_W-1:0] lookup_owner;
  logic [IDX_W-1:0]     lookup_idx;
  logic                 free_en;
  logic [NREQ-1:0]      query_hit;
  logic [CNT_W-1:0]     tbl_count;
  logic                 own_ack;

  musk_tag_table #(
    .NREQ    (NREQ),
    .MAX_OUT (MAX_OUT)
  ) u_tag_table (
    .clk          (clk),
    .reset        (reset),
    .alloc_en     (alloc_en),
    .alloc_tag    (sel_tag),
    .alloc_owner  (grant_q),
    .lookup_tag   (bus_resptag),
    .lookup_hit   (lookup_hit),
    .lookup_owner (lookup_owner),
    .lookup_idx   (lookup_idx),
    .free_en      (free_en),
    .free_idx     (lookup_idx),
    .query_tags   (m_reqtag),
    .query_hit    (query_hit),
    .count        (tbl_count)
  );

  assign m_resp     = bus_resp;
  assign m_resptag  = bus_resptag;
  assign err_orphan = err_q;

  // Select the granted requester's beat and steer the bus ack back to it.
  always_comb begin
    sel_cyc   = 1'b0;
    sel_req   = '0;
    sel_tag   = '0;
    grant_ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == ARB_OWN_W'(i)) begin
        sel_cyc      = m_reqcyc[i];
        sel_req      = m_req[i*DATA_W +: DATA_W];
        sel_tag      = m_reqtag[i*TAG_W +: TAG_W];
        grant_ack[i] = bus_reqack;
      end
    end
  end

  // Eligibility uses the registered table count, so a free only helps next cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = m_reqcyc[i] &&
                (is_write(m_reqtag[i*TAG_W +: TAG_W]) ||
                 ((tbl_count < CNT_W'(MAX_OUT)) && !query_hit[i]));
    end
  end

  // Round-robin search starting just after the last completed grant.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && elig[i] && (((int'(rr_q) + k) % NREQ) == i)) begin
          found  = 1'b1;
          winner = ARB_OWN_W'(i);
        end
      end
    end
  end

  // Request FSM next state and bus passthrough.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    beat_d     = beat_q;
    alloc_en   = 1'b0;
    bus_reqcyc = 1'b0;
    bus_req    = '0;
    bus_reqtag = '0;
    m_reqack   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = winner;
          state_d = ADDR;
        end
      end
      ADDR: begin
        bus_reqcyc = sel_cyc;
        bus_req    = sel_req;
        bus_reqtag = sel_tag;
        m_reqack   = grant_ack;
        if (sel_cyc && bus_reqack) begin
          if (is_write(sel_tag)) begin
            beat_d  = '0;
            state_d = DATA;
          end else begin
            alloc_en = 1'b1;
            rr_d     = grant_q;
            state_d  = IDLE;
          end
        end
      end
      DATA: begin
        bus_reqcyc = sel_cyc;
        bus_req    = sel_req;
        bus_reqtag = sel_tag;
        m_reqack   = grant_ack;
        if (sel_cyc && bus_reqack) begin
          if (beat_q == BEAT_W'(WR_BEATS - 1)) begin
            beat_d  = '0;
            rr_d    = grant_q;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!reset) begin
      bus_reqcyc = 1'b0;
      m_reqack   = '0;
      alloc_en   = 1'b0;
    end
  end

  // Response routing by tag; unknown tags are swallowed so the bus never stalls.
  always_comb begin
    m_respcyc   = '0;
    bus_respack = 1'b0;
    free_en     = 1'b0;
    resp_cnt_d  = resp_cnt_q;
    own_ack     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (lookup_owner == ARB_OWN_W'(i)) own_ack = m_respack[i];
    end
    if (lookup_hit) begin
      for (int i = 0; i < NREQ; i++) begin
        m_respcyc[i] = bus_respcyc && (lookup_owner == ARB_OWN_W'(i));
      end
      bus_respack = own_ack;
      if (bus_respcyc && own_ack) begin
        if (resp_cnt_q == RCNT_W'(RESP_BEATS - 1)) begin
          free_en    = 1'b1;
          resp_cnt_d = '0;
        end else begin
          resp_cnt_d = resp_cnt_q + 1'b1;
        end
      end
    end else begin
      bus_respack = 1'b1;
    end
    if (!reset) begin
      m_respcyc   = '0;
      bus_respack = 1'b0;
      free_en     = 1'b0;
    end
  end

  // State, grant, round-robin pointer and beat counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      beat_q     <= '0;
      resp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      beat_q     <= beat_d;
      resp_cnt_q <= resp_cnt_d;
    end
  end

  // Sticky orphan-response flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset)
      err_q <= 1'b0;
    else if (bus_respcyc && !lookup_hit)
      err_q <= 1'b1;
  end

endmodule
